// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//
// Four-entry first-word-fall-through FIFO. It buffers ALU results together
// with their opcode and a set of status flags that are computed on push.
//
// Optional feature (compile-time macro):
//   ALU_RES_PARITY_EN - when defined, P (out_flags[3]) holds the XOR of all
//                       eight res_in bits and is stored per entry. When the
//                       macro is undefined, P is tied to 0 and no storage is
//                       kept for it.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   ena        in   1  global enable; low holds every register
//   res_in     in   8  ALU result to store
//   res_op     in   3  opcode that produced res_in
//   res_valid  in   1  res_in/res_op valid this cycle
//   res_ready  out  1  FIFO can accept an entry (count != 4)
//   out_data   out  8  head entry result (0 when empty)
//   out_op     out  3  head entry opcode (0 when empty)
//   out_flags  out  4  head entry flags {P,N,C,Z} (0 when empty)
//   out_valid  out  1  head entry present (count != 0)
//   out_ready  in   1  consumer accepts head
//   count      out  3  occupancy 0..4
//   drop       out  1  sticky: a push was attempted while full
//   drop_clr   in   1  synchronous clear of drop
//
// Handshake: a transfer happens on a rising edge only when ena is high and
// both valid and ready are high on that side. valid never depends on ready.
// Full means no write-through, even if the head is popped on the same edge.
// -----------------------------------------------------------------------------
module alu_result_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] res_in,
    input  logic [2:0] res_op,
    input  logic       res_valid,
    output logic       res_ready,
    output logic [7:0] out_data,
    output logic [2:0] out_op,
    output logic [3:0] out_flags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] count,
    output logic       drop,
    input  logic       drop_clr
);

`ifdef ALU_RES_PARITY_EN
    localparam int FLAG_W = 4;   // {P,N,C,Z}
`else
    localparam int FLAG_W = 3;   // {N,C,Z}; P is not stored
`endif

    logic [7:0]        data_mem [4];
    logic [2:0]        op_mem   [4];
    logic [FLAG_W-1:0] flag_mem [4];

    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count_q;
    logic              drop_q;

    logic              push;
    logic              pop;
    logic [FLAG_W-1:0] push_flags;
    logic [FLAG_W-1:0] head_flags;

    assign res_ready = (count_q != 3'd4);
    assign out_valid = (count_q != 3'd0);
    assign count     = count_q;
    assign drop      = drop_q;

    assign push = ena && res_valid && res_ready;
    assign pop  = ena && out_valid && out_ready;

    // Z looks at the low nibble only, C flags anything shifted/carried into
    // the high nibble, N is bit 3 of the result.
    always_comb begin
        push_flags = '0;
`ifdef ALU_RES_PARITY_EN
        push_flags = {^res_in, res_in[3], |res_in[7:4], ~|res_in[3:0]};
`else
        push_flags = {res_in[3], |res_in[7:4], ~|res_in[3:0]};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count_q <= 3'd0;
            drop_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_mem[i] <= 8'd0;
                op_mem[i]   <= 3'd0;
                flag_mem[i] <= '0;
            end
        end else if (ena) begin
            if (push) begin
                data_mem[wr_ptr] <= res_in;
                op_mem[wr_ptr]   <= res_op;
                flag_mem[wr_ptr] <= push_flags;
                wr_ptr           <= wr_ptr + 2'd1;   // wraps 3 -> 0
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;             // wraps 3 -> 0
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
            // A refused push outranks a clear on the same edge.
            if (res_valid && (count_q == 3'd4)) begin
                drop_q <= 1'b1;
            end else if (drop_clr) begin
                drop_q <= 1'b0;
            end
        end
    end

    // Head is presented straight from storage and masked to zero when empty.
    always_comb begin
        head_flags = '0;
        out_data   = 8'd0;
        out_op     = 3'd0;
        out_flags  = 4'd0;
        if (out_valid) begin
            head_flags = flag_mem[rd_ptr];
            out_data   = data_mem[rd_ptr];
            out_op     = op_mem[rd_ptr];
`ifdef ALU_RES_PARITY_EN
            out_flags  = head_flags;
`else
            out_flags  = {1'b0, head_flags};
`endif
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] res_in = 8'd0;
  logic [2:0] res_op = 3'd0;
  logic       res_valid = 1'b0;
  logic       res_ready;
  logic [7:0] out_data;
  logic [2:0] out_op;
  logic [3:0] out_flags;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic       drop;
  logic       drop_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: entry = {flags[3:0], op[2:0], data[7:0]}
  logic [14:0] exp_q[$];
  logic        model_drop = 1'b0;

  alu_result_fifo dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .res_in(res_in), .res_op(res_op), .res_valid(res_valid), .res_ready(res_ready),
    .out_data(out_data), .out_op(out_op), .out_flags(out_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .drop(drop), .drop_clr(drop_clr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] make_entry(input logic [7:0] d, input logic [2:0] op);
    logic p;
    logic n;
    logic c;
    logic z;
`ifdef ALU_RES_PARITY_EN
    p = ^d;
`else
    p = 1'b0;
`endif
    n = d[3];
    c = (d[7:4] != 4'd0);
    z = (d[3:0] == 4'd0);
    return {p, n, c, z, op, d};
  endfunction

  // Drive one cycle of inputs from a negedge and advance to the next negedge.
  task automatic drive(input logic en, input logic rv, input logic [7:0] d,
                       input logic [2:0] op, input logic ordy, input logic dclr);
    ena       = en;
    res_valid = rv;
    res_in    = d;
    res_op    = op;
    out_ready = ordy;
    drop_clr  = dclr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'd0, 3'd0, 1'b0, 1'b0);
  endtask

  // ---------------- reference model update ----------------
  always @(negedge rst_n) begin
    exp_q.delete();
    model_drop = 1'b0;
  end

  always @(posedge clk) begin
    int sz;
    if (rst_n && ena) begin
      sz = exp_q.size();
      if (res_valid && sz == 4) model_drop = 1'b1;
      else if (drop_clr) model_drop = 1'b0;
      if (out_ready && sz > 0) void'(exp_q.pop_front());
      if (res_valid && sz < 4) exp_q.push_back(make_entry(res_in, res_op));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [14:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 15'd0;
    check("count",     32'(count),     32'(exp_q.size()));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("res_ready", 32'(res_ready), 32'(exp_q.size() != 4));
    check("drop",      32'(drop),      32'(model_drop));
    check("out_data",  32'(out_data),  32'(head[7:0]));
    check("out_op",    32'(out_op),    32'(head[10:8]));
    check("out_flags", 32'(out_flags), 32'(head[14:11]));
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset state, immediately after time 0
    #2;
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res_ready", 32'(res_ready), 32'd1);
    check("rst_drop",      32'(drop),      32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // single push, one-cycle latency
    drive(1'b1, 1'b1, 8'h05, 3'd0, 1'b0, 1'b0);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_data",  32'(out_data),  32'h05);
    check("lat_flags",     32'(out_flags[2:0]), 32'd0);
    check("lat_count",     32'(count),     32'd1);
    drive(1'b1, 1'b0, 8'd0, 3'd0, 1'b1, 1'b0);   // pop it
    check("drain_empty", 32'(count), 32'd0);

    // fill with directed pattern
    drive(1'b1, 1'b1, 8'h10, 3'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h0F, 3'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hF8, 3'd3, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0);
    check("full_count",     32'(count),     32'd4);
    check("full_res_ready", 32'(res_ready), 32'd0);
    check("full_head_zcn",  32'({out_flags[0], out_flags[1], out_flags[2]}), 32'b110);

    // push while full -> drop; set and clear together -> set wins; then clear
    drive(1'b1, 1'b1, 8'hAA, 3'd5, 1'b0, 1'b0);
    check("drop_set",   32'(drop),  32'd1);
    check("drop_count", 32'(count), 32'd4);
    drive(1'b1, 1'b1, 8'hBB, 3'd5, 1'b0, 1'b1);
    check("drop_set_wins", 32'(drop), 32'd1);
    drive(1'b1, 1'b0, 8'd0, 3'd0, 1'b0, 1'b1);
    check("drop_clr", 32'(drop), 32'd0);
    // pop with push on full: no write-through
    drive(1'b1, 1'b1, 8'hCC, 3'd6, 1'b1, 1'b0);
    check("no_wt_count", 32'(count), 32'd3);
    check("no_wt_head",  32'(out_data), 32'h0F);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'd0, 3'd0, 1'b1, 1'b0);
    check("drained", 32'(count), 32'd0);

    // simultaneous push/pop at count=2, six cycles for pointer wrap
    drive(1'b1, 1'b1, 8'h21, 3'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h42, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'b1, 1'b0);
      check("pp_count", 32'(count), 32'd2);
    end
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 8'd0, 3'd0, 1'b1, 1'b0);

    // enable low freezes everything
    drive(1'b1, 1'b1, 8'h33, 3'd3, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h44, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h55, 3'd5, 1'b1, 1'b1);
      check("ena_low_count", 32'(count),    32'd2);
      check("ena_low_head",  32'(out_data), 32'h33);
    end

    // parity of 0x07 (three ones)
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 8'd0, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 8'h07, 3'd7, 1'b0, 1'b0);
`ifdef ALU_RES_PARITY_EN
    check("parity_07", 32'(out_flags[3]), 32'd1);
`else
    check("parity_07", 32'(out_flags[3]), 32'd0);
`endif
    drive(1'b1, 1'b0, 8'd0, 3'd0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
    end

    // mid-stream asynchronous reset
    idle(1);
    drive(1'b1, 1'b1, 8'h5A, 3'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hA5, 3'd3, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count",     32'(count),     32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    drive(1'b1, 1'b1, 8'h3C, 3'd1, 1'b0, 1'b0);
    check("post_rst_count", 32'(count),    32'd1);
    check("post_rst_head",  32'(out_data), 32'h3C);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
